y86_seq_sequencer: RTL and testbench
====================================

// Module: y86_seq_sequencer
// PURPOSE
//  Multi-cycle controller for the Y86-64 SEQ core: holds PC and the architectural status register.
//  Steps each instruction through the FETCH..PC_UPD stage enables, with req/ack handshakes to
//  instruction and data memory plus a wait-state timeout. Faults park the core in a HALTED state
//  with a status code instead of ending simulation. Sits between the top level and the stage blocks.
// PARAMETERS
//  ADDR_W       64  PC / pc_new width
//  RESET_PC     0   PC value after reset or clear
//  CNT_W        32  width of cycle and retired-instruction counters
//  MEM_TIMEOUT  16  max wait cycles for any ack before an ADR fault (>=1)
// PORTS
//  clk            in   1       clock, rising edge
//  rst_n          in   1       asynchronous, active-low reset
//  run            in   1       level: execute while high; sampled at IDLE and at PC_UPD
//  clear          in   1       in IDLE/HALTED only: pc<=RESET_PC, stat<=AOK, counters<=0
//  imem_req       out  1       fetch request, held high until imem_ack
//  imem_ack       in   1       fetch done; fault flags are valid in this cycle
//  imem_error     in   1       fetch address fault
//  invalid_instr  in   1       illegal icode/ifun
//  halt_instr     in   1       fetched instruction is halt
//  mem_op         in   1       decoded instruction touches data memory (from decode)
//  dmem_req       out  1       data request, held high until dmem_ack
//  dmem_ack       in   1       data access done
//  dmem_error     in   1       data address fault, valid with dmem_ack
//  pc_new         in   ADDR_W  next PC from pc_update logic
//  pc             out  ADDR_W  current PC
//  dec_en/exe_en/wb_en out 1   one-hot stage strobes, 1 cycle each
//  stat           out  2       AOK=0 HLT=1 ADR=2 INS=3
//  cycles         out  CNT_W   active cycles (not IDLE/HALTED), saturating
//  retired        out  CNT_W   retired instructions incl. halt, saturating
// BEHAVIOUR
//  Reset (async): state IDLE, pc=RESET_PC, stat=AOK, all req/strobes 0, counters 0.
//  States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PC_UPD, HALTED.
//  IDLE: run=1 -> FETCH; clear is honoured only in IDLE/HALTED and wins over run.
//  FETCH: imem_req=1. On ack, priority imem_error(ADR) > invalid_instr(INS) > halt_instr(HLT).
//   Any of these -> HALTED with that stat, pc unchanged. HLT also increments retired. Else -> DECODE.
//  DECODE/EXECUTE: dec_en/exe_en high for exactly 1 cycle each.
//  MEMORY: if mem_op=0, 1 cycle. Else dmem_req until dmem_ack; dmem_error -> ADR, HALTED,
//   no wb_en, no pc update.
//  WRITEBACK: wb_en for 1 cycle. PC_UPD: pc<=pc_new, retired++; run=1 -> FETCH, else IDLE.
//  Handshakes: ack is accepted in the same cycle req rises (zero-wait) -> 6 cycles/instruction.
//   Each wait cycle adds 1. Ack without req is ignored.
//  Timeout: wait counter clears on req entry. If MEM_TIMEOUT cycles pass with no ack -> ADR, HALTED.
//   Ack in the same cycle as expiry wins: no fault.
//  run falling mid-instruction: the instruction completes, then the core parks in IDLE.
//  HALTED: all req/strobes 0, stat held; leaves only via clear (-> IDLE) or reset.
//  Counters saturate at all-ones; no wrap. pc is stored as given; no alignment check.
//  rst_n low mid-handshake drops req/strobes the same instant; no completion is recorded.
// STRUCTURE
//  y86_pkg: stat code localparams (AOK/HLT/ADR/INS), state encoding.
//  Sub-module y86_mem_wait_timer (start, ack, expired), one instance shared by FETCH and MEMORY.
// TESTING
//  1 Zero-wait run: irmovq, addq, halt at pc 0,10,12 -> 13 cycles, retired=3, stat=HLT, pc=12.
//  2 Fetch with 3 wait states -> imem_req high 4 cycles; instruction takes 9 cycles; stat=AOK.
//  3 No ack, MEM_TIMEOUT=4 -> ADR after 4 wait cycles; req drops; retired unchanged.
//    Repeat with ack on the 4th cycle -> no fault.
//  4 imem_error and invalid_instr together with ack -> stat=ADR. invalid_instr alone -> INS.
//  5 run pulsed for 1 cycle -> exactly one instruction retires, then IDLE.
//    clear in HALTED -> pc=0, stat=AOK, counters=0.
//  6 rst_n low during MEMORY wait -> dmem_req=0 immediately; after release pc=RESET_PC, state IDLE.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared definitions for the Y86-64 SEQ sequencer: status codes and FSM state encoding.
package y86_pkg;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_PC_UPD    = 3'd6,
    ST_HALTED    = 3'd7
  } state_e;

endpackage

// File: rtl/y86_mem_wait_timer.sv
// Wait-state timer shared by the instruction and data memory handshakes.
// expired_o rises in the TIMEOUT-th cycle of a request that has not been acked.
module y86_mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  input  logic ack_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired_o = req_i && (cnt_q == CW'(TIMEOUT - 1));

  // Every request is entered from a cycle with req low, so the count is
  // already zero on request entry.
  always_comb begin
    cnt_d = '0;
    if (req_i && !ack_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/y86_seq_sequencer.sv
// Multi-cycle controller for the Y86-64 SEQ core: PC, status register, stage
// strobes, memory handshakes with timeout, and cycle/retire counters.
module y86_seq_sequencer
  import y86_pkg::*;
#(
  parameter int                ADDR_W      = 64,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                CNT_W       = 32,
  parameter int                MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              clear,
  output logic              imem_req,
  input  logic              imem_ack,
  input  logic              imem_error,
  input  logic              invalid_instr,
  input  logic              halt_instr,
  input  logic              mem_op,
  output logic              dmem_req,
  input  logic              dmem_ack,
  input  logic              dmem_error,
  input  logic [ADDR_W-1:0] pc_new,
  output logic [ADDR_W-1:0] pc,
  output logic              dec_en,
  output logic              exe_en,
  output logic              wb_en,
  output logic [1:0]        stat,
  output logic [CNT_W-1:0]  cycles,
  output logic [CNT_W-1:0]  retired,
  output logic [2:0]        dbg_state
);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [1:0]         stat_q, stat_d;
  logic [CNT_W-1:0]   cycles_q, cycles_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               wait_req, wait_ack, wait_expired;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Handshake: req is a pure function of state and stays high until the
  // cycle in which ack is seen with it; ack while req is low is ignored.
  assign imem_req  = (state_q == ST_FETCH);
  assign dmem_req  = (state_q == ST_MEMORY) && mem_op;
  assign dec_en    = (state_q == ST_DECODE);
  assign exe_en    = (state_q == ST_EXECUTE);
  assign wb_en     = (state_q == ST_WRITEBACK);
  assign wait_req  = imem_req | dmem_req;
  assign wait_ack  = (imem_req & imem_ack) | (dmem_req & dmem_ack);

  assign pc        = pc_q;
  assign stat      = stat_q;
  assign cycles    = cycles_q;
  assign retired   = retired_q;
  assign dbg_state = state_q;

  y86_mem_wait_timer #(
    .TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (wait_req),
    .ack_i    (wait_ack),
    .expired_o(wait_expired)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    stat_d    = stat_q;
    cycles_d  = cycles_q;
    retired_d = retired_q;

    if (state_q != ST_IDLE && state_q != ST_HALTED) begin
      cycles_d = sat_inc(cycles_q);
    end

    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          pc_d      = RESET_PC;
          stat_d    = STAT_AOK;
          cycles_d  = '0;
          retired_d = '0;
        end else if (run) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (imem_ack) begin
          if (imem_error) begin
            stat_d  = STAT_ADR;
            state_d = ST_HALTED;
          end else if (invalid_instr) begin
            stat_d  = STAT_INS;
            state_d = ST_HALTED;
          end else if (halt_instr) begin
            stat_d    = STAT_HLT;
            retired_d = sat_inc(retired_q);
            state_d   = ST_HALTED;
          end else begin
            state_d = ST_DECODE;
          end
        end else if (wait_expired) begin
          stat_d  = STAT_ADR;
          state_d = ST_HALTED;
        end
      end
      ST_DECODE:  state_d = ST_EXECUTE;
      ST_EXECUTE: state_d = ST_MEMORY;
      ST_MEMORY: begin
        if (!mem_op) begin
          state_d = ST_WRITEBACK;
        end else if (dmem_ack) begin
          if (dmem_error) begin
            stat_d  = STAT_ADR;
            state_d = ST_HALTED;
          end else begin
            state_d = ST_WRITEBACK;
          end
        end else if (wait_expired) begin
          stat_d  = STAT_ADR;
          state_d = ST_HALTED;
        end
      end
      ST_WRITEBACK: state_d = ST_PC_UPD;
      ST_PC_UPD: begin
        pc_d      = pc_new;
        retired_d = sat_inc(retired_q);
        state_d   = run ? ST_FETCH : ST_IDLE;
      end
      ST_HALTED: begin
        if (clear) begin
          pc_d      = RESET_PC;
          stat_d    = STAT_AOK;
          cycles_d  = '0;
          retired_d = '0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      stat_q    <= STAT_AOK;
      cycles_q  <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      stat_q    <= stat_d;
      cycles_q  <= cycles_d;
      retired_q <= retired_d;
    end
  end

endmodule

// File: tb/tb_y86_seq_sequencer.sv
// Bench for y86_seq_sequencer: directed vector table, hand sequences for
// reset/clear corners, and randomized instruction streams against a cycle-count model.
module tb_y86_seq_sequencer;
  import y86_pkg::*;

  localparam int T       = 4;
  localparam int CNT_MAX = 255;
  localparam logic [1:0] AOK = 2'd0, HLT = 2'd1, ADR = 2'd2, INS = 2'd3;

  logic        clk, rst_n, run, clear;
  logic        imem_req, imem_ack, imem_error, invalid_instr, halt_instr, mem_op;
  logic        dmem_req, dmem_ack, dmem_error;
  logic [63:0] pc_new, pc;
  logic        dec_en, exe_en, wb_en;
  logic [1:0]  stat;
  logic [7:0]  cycles, retired;
  logic [2:0]  dbg_state;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int fw; bit ie; bit ii; bit hi; bit mop; int dw; bit de; logic [63:0] pnew;
  } plan_t;

  typedef struct {
    plan_t p; int n; logic [1:0] stat; logic [63:0] pc; int ret; int ireq; int dreq; int wb;
  } vec_t;

  typedef struct {
    int n; logic [1:0] stat; bit halted; bit retire; bit pc_upd; int ireq; int dreq; int dec; int wb;
  } exp_t;

  vec_t vq[$];

  y86_seq_sequencer #(
    .ADDR_W(64), .RESET_PC(64'h0), .CNT_W(8), .MEM_TIMEOUT(T)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .clear(clear),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_error(imem_error),
    .invalid_instr(invalid_instr), .halt_instr(halt_instr), .mem_op(mem_op),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack), .dmem_error(dmem_error),
    .pc_new(pc_new), .pc(pc), .dec_en(dec_en), .exe_en(exe_en), .wb_en(wb_en),
    .stat(stat), .cycles(cycles), .retired(retired), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic quiet();
    clear = 0; imem_ack = 0; imem_error = 0; invalid_instr = 0; halt_instr = 0;
    dmem_ack = 0; dmem_error = 0; mem_op = 0;
  endtask

  task automatic do_clear();
    run = 0; clear = 1;
    @(negedge clk);
    clear = 0;
  endtask

  task automatic start();
    clear = 0; run = 1;
    @(negedge clk);
  endtask

  // Memory responder: acks fetch after p.fw wait cycles and data after p.dw,
  // drives junk on flags/acks when they must be ignored.
  task automatic run_instr(input plan_t p, input int n, input bit hold,
                           output int c_ireq, output int c_dreq, output int c_dec, output int c_wb);
    int fcnt = 0;
    int dcnt = 0;
    c_ireq = 0; c_dreq = 0; c_dec = 0; c_wb = 0;
    for (int i = 0; i < n; i++) begin
      if (!hold) run = 1'b0;
      c_ireq += int'(imem_req);
      c_dreq += int'(dmem_req);
      c_dec  += int'(dec_en);
      c_wb   += int'(wb_en);
      mem_op = p.mop;
      pc_new = p.pnew;
      clear  = 1'($urandom_range(0, 1));
      if (imem_req && fcnt == p.fw) begin
        imem_ack = 1; imem_error = p.ie; invalid_instr = p.ii; halt_instr = p.hi;
      end else begin
        imem_ack = imem_req ? 1'b0 : 1'($urandom_range(0, 1));
        imem_error = 1'($urandom_range(0, 1));
        invalid_instr = 1'($urandom_range(0, 1));
        halt_instr = 1'($urandom_range(0, 1));
      end
      if (imem_req) fcnt++;
      if (dmem_req && dcnt == p.dw) begin
        dmem_ack = 1; dmem_error = p.de;
      end else begin
        dmem_ack = dmem_req ? 1'b0 : 1'($urandom_range(0, 1));
        dmem_error = 1'($urandom_range(0, 1));
      end
      if (dmem_req) dcnt++;
      @(negedge clk);
    end
    quiet();
  endtask

  // Expected outcome of one instruction from its wait/fault plan.
  function automatic exp_t model(input plan_t p);
    exp_t e;
    int mc;
    e.stat = AOK; e.halted = 0; e.retire = 0; e.pc_upd = 0;
    e.dreq = 0; e.dec = 0; e.wb = 0;
    e.ireq = (p.fw < T) ? p.fw + 1 : T;
    if (p.fw >= T) begin
      e.n = T; e.stat = ADR; e.halted = 1;
    end else if (p.ie || p.ii || p.hi) begin
      e.n = p.fw + 1; e.halted = 1;
      e.stat = p.ie ? ADR : (p.ii ? INS : HLT);
      e.retire = !p.ie && !p.ii;
    end else begin
      e.dec = 1;
      mc = 1;
      if (p.mop) begin
        mc = (p.dw < T) ? p.dw + 1 : T;
        e.dreq = mc;
        if (p.dw >= T || p.de) begin
          e.halted = 1; e.stat = ADR;
        end
      end
      e.n = p.fw + 3 + mc;
      if (!e.halted) begin
        e.n += 2; e.wb = 1; e.retire = 1; e.pc_upd = 1;
      end
    end
    return e;
  endfunction

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  task automatic add_vec(input int fw, input bit ie, input bit ii, input bit hi, input bit mop,
                         input int dw, input bit de, input logic [63:0] pnew, input int n,
                         input logic [1:0] st, input logic [63:0] epc, input int ret,
                         input int ireq, input int dreq, input int wb);
    vec_t v;
    v.p = '{fw: fw, ie: ie, ii: ii, hi: hi, mop: mop, dw: dw, de: de, pnew: pnew};
    v.n = n; v.stat = st; v.pc = epc; v.ret = ret; v.ireq = ireq; v.dreq = dreq; v.wb = wb;
    vq.push_back(v);
  endtask

  // Model-tracked architectural state for the streaming phases.
  logic [63:0] m_pc;
  logic [1:0]  m_stat;
  int          m_ret, m_cyc;

  task automatic stream(input int count, input bit faults, input string tag);
    plan_t p;
    exp_t e;
    int ci, cd, cdec, cw;
    for (int k = 0; k < count; k++) begin
      p.fw   = (faults && $urandom_range(0, 7) == 0) ? T : $urandom_range(0, faults ? 3 : 1);
      p.ie   = faults && ($urandom_range(0, 15) == 0);
      p.ii   = faults && ($urandom_range(0, 15) == 0);
      p.hi   = faults && ($urandom_range(0, 15) == 0);
      p.mop  = 1'($urandom_range(0, 1));
      p.dw   = (faults && $urandom_range(0, 7) == 0) ? T : $urandom_range(0, 2);
      p.de   = faults && ($urandom_range(0, 15) == 0);
      p.pnew = {$urandom, $urandom};
      e = model(p);
      run_instr(p, e.n, 1'b1, ci, cd, cdec, cw);
      m_cyc = sat(m_cyc + e.n);
      if (e.retire) m_ret = sat(m_ret + 1);
      if (e.pc_upd) m_pc = p.pnew;
      m_stat = e.stat;
      chk($sformatf("%s%0d stat", tag, k), 64'(stat), 64'(m_stat));
      chk($sformatf("%s%0d pc", tag, k), pc, m_pc);
      chk($sformatf("%s%0d retired", tag, k), 64'(retired), 64'(m_ret));
      chk($sformatf("%s%0d cycles", tag, k), 64'(cycles), 64'(m_cyc));
      chk($sformatf("%s%0d imem_req cycles", tag, k), 64'(ci), 64'(e.ireq));
      chk($sformatf("%s%0d dmem_req cycles", tag, k), 64'(cd), 64'(e.dreq));
      chk($sformatf("%s%0d dec_en pulses", tag, k), 64'(cdec), 64'(e.dec));
      chk($sformatf("%s%0d wb_en pulses", tag, k), 64'(cw), 64'(e.wb));
      chk($sformatf("%s%0d next fetch", tag, k), 64'(imem_req), 64'(!e.halted));
      if (e.halted) begin
        do_clear();
        m_pc = 64'h0; m_stat = AOK; m_ret = 0; m_cyc = 0;
        chk($sformatf("%s%0d clear stat", tag, k), 64'(stat), 64'(AOK));
        start();
      end
    end
  endtask

  initial begin
    plan_t p;
    int ci, cd, cdec, cw;

    // zero-wait / wait-state / timeout / fault-priority / data-path vectors
    add_vec(0, 0, 0, 0, 0, 0, 0, 64'h0A, 6, AOK, 64'h0A, 1, 1, 0, 1);
    add_vec(3, 0, 0, 0, 0, 0, 0, 64'h20, 9, AOK, 64'h20, 1, 4, 0, 1);
    add_vec(4, 0, 0, 0, 0, 0, 0, 64'h24, 4, ADR, 64'h00, 0, 4, 0, 0);
    add_vec(0, 1, 1, 0, 0, 0, 0, 64'h24, 1, ADR, 64'h00, 0, 1, 0, 0);
    add_vec(0, 0, 1, 0, 0, 0, 0, 64'h24, 1, INS, 64'h00, 0, 1, 0, 0);
    add_vec(2, 0, 0, 1, 0, 0, 0, 64'h24, 3, HLT, 64'h00, 1, 3, 0, 0);
    add_vec(0, 0, 1, 1, 0, 0, 0, 64'h24, 1, INS, 64'h00, 0, 1, 0, 0);
    add_vec(0, 1, 0, 1, 0, 0, 0, 64'h24, 1, ADR, 64'h00, 0, 1, 0, 0);
    add_vec(0, 0, 0, 0, 1, 0, 0, 64'h30, 6, AOK, 64'h30, 1, 1, 1, 1);
    add_vec(0, 0, 0, 0, 1, 2, 0, 64'h38, 8, AOK, 64'h38, 1, 1, 3, 1);
    add_vec(0, 0, 0, 0, 1, 1, 1, 64'h40, 5, ADR, 64'h00, 0, 1, 2, 0);
    add_vec(0, 0, 0, 0, 1, 4, 0, 64'h40, 7, ADR, 64'h00, 0, 1, 4, 0);
    add_vec(1, 0, 0, 0, 1, 3, 0, 64'h48, 10, AOK, 64'h48, 1, 2, 4, 1);
    add_vec(0, 0, 0, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFF3, 6, AOK, 64'hFFFF_FFFF_FFFF_FFF3, 1, 1, 0, 1);
    add_vec(3, 0, 0, 1, 0, 0, 0, 64'h50, 4, HLT, 64'h00, 1, 4, 0, 0);

    rst_n = 0; run = 0; pc_new = '0;
    quiet();
    repeat (2) @(negedge clk);
    chk("reset state", 64'(dbg_state), 64'(ST_IDLE));
    chk("reset pc", pc, 64'h0);
    chk("reset stat", 64'(stat), 64'(AOK));
    chk("reset cycles", 64'(cycles), 64'h0);
    chk("reset retired", 64'(retired), 64'h0);
    chk("reset reqs/strobes", 64'({imem_req, dmem_req, dec_en, exe_en, wb_en}), 64'h0);
    rst_n = 1;
    repeat (2) @(negedge clk);
    chk("idle without run", 64'(imem_req), 64'h0);

    // Each vector: one instruction with run pulsed for a single cycle.
    foreach (vq[i]) begin
      do_clear();
      start();
      run_instr(vq[i].p, vq[i].n, 1'b0, ci, cd, cdec, cw);
      chk($sformatf("vec%0d stat", i), 64'(stat), 64'(vq[i].stat));
      chk($sformatf("vec%0d pc", i), pc, vq[i].pc);
      chk($sformatf("vec%0d retired", i), 64'(retired), 64'(vq[i].ret));
      chk($sformatf("vec%0d cycles", i), 64'(cycles), 64'(vq[i].n));
      chk($sformatf("vec%0d imem_req cycles", i), 64'(ci), 64'(vq[i].ireq));
      chk($sformatf("vec%0d dmem_req cycles", i), 64'(cd), 64'(vq[i].dreq));
      chk($sformatf("vec%0d wb_en pulses", i), 64'(cw), 64'(vq[i].wb));
      @(negedge clk);
      chk($sformatf("vec%0d parked", i), 64'({imem_req, dmem_req}), 64'h0);
      chk($sformatf("vec%0d parked cycles", i), 64'(cycles), 64'(vq[i].n));
    end

    // irmovq @0, addq @10, halt @12 with run held high
    do_clear();
    start();
    p = '{fw: 0, ie: 0, ii: 0, hi: 0, mop: 0, dw: 0, de: 0, pnew: 64'd10};
    run_instr(p, 6, 1'b1, ci, cd, cdec, cw);
    p.pnew = 64'd12;
    run_instr(p, 6, 1'b1, ci, cd, cdec, cw);
    p.hi = 1;
    run_instr(p, 1, 1'b1, ci, cd, cdec, cw);
    chk("prog cycles", 64'(cycles), 64'd13);
    chk("prog retired", 64'(retired), 64'd3);
    chk("prog stat", 64'(stat), 64'(HLT));
    chk("prog pc", pc, 64'd12);
    repeat (2) @(negedge clk);
    chk("halted holds", 64'({imem_req, stat}), 64'({1'b0, HLT}));
    do_clear();
    chk("clear pc", pc, 64'h0);
    chk("clear stat", 64'(stat), 64'(AOK));
    chk("clear counters", 64'({cycles, retired}), 64'h0);
    chk("clear to idle", 64'(dbg_state), 64'(ST_IDLE));

    // clear beats run in IDLE
    clear = 1; run = 1;
    @(negedge clk);
    chk("clear wins over run", 64'(imem_req), 64'h0);
    clear = 0;
    @(negedge clk);
    chk("run after clear", 64'(imem_req), 64'h1);
    p = '{fw: 0, ie: 0, ii: 0, hi: 0, mop: 0, dw: 0, de: 0, pnew: 64'h40};
    run_instr(p, 6, 1'b1, ci, cd, cdec, cw);
    chk("pre-reset pc", pc, 64'h40);

    // reset asserted while waiting on data memory
    mem_op = 1; imem_ack = 1;
    @(negedge clk);
    imem_ack = 0;
    repeat (2) @(negedge clk);
    chk("in memory wait", 64'(dmem_req), 64'h1);
    #2 rst_n = 0;
    #1;
    chk("reset drops dmem_req", 64'(dmem_req), 64'h0);
    chk("reset pc mid-op", pc, 64'h0);
    chk("reset retired mid-op", 64'(retired), 64'h0);
    @(negedge clk);
    quiet(); run = 0; rst_n = 1;
    @(negedge clk);
    chk("idle after reset", 64'(dbg_state), 64'(ST_IDLE));

    // random streams, then a long fault-free stream to saturate counters
    do_clear();
    m_pc = 64'h0; m_stat = AOK; m_ret = 0; m_cyc = 0;
    start();
    stream(150, 1'b1, "rnd");
    run = 0;
    repeat (12) @(negedge clk);
    do_clear();
    m_pc = 64'h0; m_stat = AOK; m_ret = 0; m_cyc = 0;
    start();
    stream(270, 1'b0, "sat");
    chk("sat cycles", 64'(cycles), 64'hFF);
    chk("sat retired", 64'(retired), 64'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
